// File: rtl/mul_adr_pkg.sv
// Shared widths, FSM state encoding and the expected-result record for the
// multiplier/adder operand generator.
package mul_adr_pkg;

   localparam int OP_W    = 8;
   localparam int PROD_W  = 16;
   localparam int SUM_W   = 9;
   localparam int ERR_W   = 17;
   localparam int LAT_MAX = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   // One presented vector travelling towards the compare point.
   typedef struct packed {
      logic            vld;
      logic            mode;
      logic [OP_W-1:0] a;
      logic [OP_W-1:0] b;
   } exp_t;

   function automatic logic [PROD_W-1:0] ref_prod(input logic [OP_W-1:0] a,
                                                  input logic [OP_W-1:0] b);
      return PROD_W'(a) * PROD_W'(b);
   endfunction

   function automatic logic [SUM_W-1:0] ref_sum(input logic [OP_W-1:0] a,
                                                input logic [OP_W-1:0] b);
      return SUM_W'(a) + SUM_W'(b);
   endfunction

endpackage

// File: rtl/mul_adr_exp_pipe.sv
// LAT-deep delay line aligning presented vectors with the consumer's results;
// LAT = 0 is a straight pass-through.
module mul_adr_exp_pipe
   import mul_adr_pkg::*;
#(
   parameter int LAT = 1
) (
   input  logic clk,
   input  logic rst,
   input  exp_t din,
   output exp_t dout
);

   generate
      if (LAT == 0) begin : g_comb
         logic unused_pipe;
         assign unused_pipe = clk ^ rst;
         assign dout = din;
      end else begin : g_reg
         exp_t stg_q [LAT];
         exp_t stg_d [LAT];

         always_comb begin
            stg_d[0] = din;
            for (int i = 1; i < LAT; i++) stg_d[i] = stg_q[i-1];
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int i = 0; i < LAT; i++) stg_q[i] <= '0;
            end else begin
               for (int i = 0; i < LAT; i++) stg_q[i] <= stg_d[i];
            end
         end

         assign dout = stg_q[LAT-1];
      end
   endgenerate

endmodule

// File: rtl/mul_adr_opgen.sv
// Exhaustive operand sweep generator for an 8x8 multiplier or 8+8 adder, with
// optional result checking enabled by the macro MUL_ADR_OPGEN_CHK_EN.
module mul_adr_opgen
   import mul_adr_pkg::*;
#(
   parameter int LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              mode,
   input  logic              hold,
   output logic [OP_W-1:0]   am_out,
   output logic [OP_W-1:0]   bm_out,
   output logic [OP_W-1:0]   aa_out,
   output logic [OP_W-1:0]   ba_out,
   output logic              op_vld,
   input  logic [PROD_W-1:0] p_in,
   input  logic [SUM_W-1:0]  s_in,
   output logic              busy,
   output logic              done,
   output logic [ERR_W-1:0]  err_cnt,
   output logic [OP_W-1:0]   first_err_a,
   output logic [OP_W-1:0]   first_err_b,
   output state_e            state_dbg
);

   localparam logic [2:0] DRAIN_INIT = (LAT > 0) ? 3'(LAT - 1) : 3'd0;

   state_e          state_q, state_d;
   logic [15:0]     tv_q, tv_d, tv_inc;
   logic            mode_q, mode_d;
   logic [OP_W-1:0] a_q, a_d, b_q, b_d;
   logic            op_vld_q, op_vld_d;
   logic            busy_q, busy_d, done_q, done_d;
   logic [2:0]      drain_q, drain_d;
   logic            clr_chk;

   always_comb begin
      state_d  = state_q;
      tv_d     = tv_q;
      mode_d   = mode_q;
      a_d      = a_q;
      b_d      = b_q;
      op_vld_d = 1'b0;
      drain_d  = drain_q;
      clr_chk  = 1'b0;
      tv_inc   = tv_q + 16'd1;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               mode_d   = mode;
               tv_d     = '0;
               a_d      = '0;
               b_d      = '0;
               op_vld_d = 1'b1;
               clr_chk  = 1'b1;
               state_d  = ST_RUN;
            end
         end
         ST_RUN: begin
            // tv holds the vector currently on the ports; advance only when not held.
            if (!hold) begin
               if (tv_q == 16'hFFFF) begin
                  state_d = (LAT == 0) ? ST_DONE : ST_DRAIN;
                  drain_d = DRAIN_INIT;
               end else begin
                  tv_d     = tv_inc;
                  a_d      = tv_inc[15:8];
                  b_d      = tv_inc[7:0];
                  op_vld_d = 1'b1;
               end
            end
         end
         ST_DRAIN: begin
            if (drain_q == 3'd0) state_d = ST_DONE;
            else                 drain_d = drain_q - 3'd1;
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         tv_q     <= '0;
         mode_q   <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         op_vld_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         drain_q  <= '0;
      end else begin
         state_q  <= state_d;
         tv_q     <= tv_d;
         mode_q   <= mode_d;
         a_q      <= a_d;
         b_q      <= b_d;
         op_vld_q <= op_vld_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         drain_q  <= drain_d;
      end
   end

   // Only the pair selected by the latched mode carries the operands.
   assign am_out    = mode_q ? '0 : a_q;
   assign bm_out    = mode_q ? '0 : b_q;
   assign aa_out    = mode_q ? a_q : '0;
   assign ba_out    = mode_q ? b_q : '0;
   assign op_vld    = op_vld_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign state_dbg = state_q;

`ifdef MUL_ADR_OPGEN_CHK_EN
   exp_t             pipe_in, pipe_out;
   logic             mismatch;
   logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
   logic [OP_W-1:0]  ferr_a_q, ferr_a_d, ferr_b_q, ferr_b_d;

   assign pipe_in = '{vld: op_vld_q, mode: mode_q, a: a_q, b: b_q};

   mul_adr_exp_pipe #(.LAT(LAT)) u_exp_pipe (
      .clk  (clk),
      .rst  (rst),
      .din  (pipe_in),
      .dout (pipe_out)
   );

   always_comb begin
      mismatch  = 1'b0;
      err_cnt_d = err_cnt_q;
      ferr_a_d  = ferr_a_q;
      ferr_b_d  = ferr_b_q;
      if (pipe_out.vld) begin
         if (pipe_out.mode) mismatch = (s_in != ref_sum(pipe_out.a, pipe_out.b));
         else               mismatch = (p_in != ref_prod(pipe_out.a, pipe_out.b));
      end
      if (clr_chk) begin
         err_cnt_d = '0;
         ferr_a_d  = '0;
         ferr_b_d  = '0;
      end else if (mismatch) begin
         if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
         if (err_cnt_q == '0) begin
            ferr_a_d = pipe_out.a;
            ferr_b_d = pipe_out.b;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_cnt_q <= '0;
         ferr_a_q  <= '0;
         ferr_b_q  <= '0;
      end else begin
         err_cnt_q <= err_cnt_d;
         ferr_a_q  <= ferr_a_d;
         ferr_b_q  <= ferr_b_d;
      end
   end

   assign err_cnt     = err_cnt_q;
   assign first_err_a = ferr_a_q;
   assign first_err_b = ferr_b_q;
`else
   logic unused_chk;
   assign unused_chk  = ^{p_in, s_in, clr_chk};
   assign err_cnt     = '0;
   assign first_err_a = '0;
   assign first_err_b = '0;
`endif

endmodule

// File: tb/tb_mul_adr_opgen.sv
// Bench for mul_adr_opgen: two instances sweep in parallel (LAT=1 multiply with
// hold and an injected fault, LAT=0 add), then a reset/restart sequence.
module tb_mul_adr_opgen;
   import mul_adr_pkg::*;

`ifdef MUL_ADR_OPGEN_CHK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Multiply instance, LAT = 1
   logic        rst_m, start_m, mode_m, hold_m;
   logic [7:0]  am_m, bm_m, aa_m, ba_m, fa_m, fb_m;
   logic        op_vld_m, busy_m, done_m;
   logic [15:0] p_m;
   logic [16:0] err_m;
   state_e      state_m;

   // Add instance, LAT = 0
   logic        rst_s, start_s, mode_s, hold_s;
   logic [7:0]  am_s, bm_s, aa_s, ba_s, fa_s, fb_s;
   logic        op_vld_s, busy_s, done_s;
   logic [8:0]  s_s;
   logic [16:0] err_s;
   state_e      state_s;

   mul_adr_opgen #(.LAT(1)) u_m (
      .clk(clk), .rst(rst_m), .start(start_m), .mode(mode_m), .hold(hold_m),
      .am_out(am_m), .bm_out(bm_m), .aa_out(aa_m), .ba_out(ba_m), .op_vld(op_vld_m),
      .p_in(p_m), .s_in(9'd0), .busy(busy_m), .done(done_m), .err_cnt(err_m),
      .first_err_a(fa_m), .first_err_b(fb_m), .state_dbg(state_m)
   );

   mul_adr_opgen #(.LAT(0)) u_s (
      .clk(clk), .rst(rst_s), .start(start_s), .mode(mode_s), .hold(hold_s),
      .am_out(am_s), .bm_out(bm_s), .aa_out(aa_s), .ba_out(ba_s), .op_vld(op_vld_s),
      .p_in(16'd0), .s_in(s_s), .busy(busy_s), .done(done_s), .err_cnt(err_s),
      .first_err_a(fa_s), .first_err_b(fb_s), .state_dbg(state_s)
   );

   // Consumers: registered multiplier with a stuck-at-zero product for 3*5,
   // and an ideal combinational adder.
   always @(posedge clk) p_m <= (am_m == 8'd3 && bm_m == 8'd5) ? 16'd0 : 16'(am_m) * 16'(bm_m);
   assign s_s = 9'(aa_s) + 9'(ba_s);

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   typedef struct {
      int          idx;
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] prod;
      logic [8:0]  sum;
   } vec_t;
   vec_t tbl [5];

   // Sweep monitor: vectors must appear strictly in order 0..0xFFFF
   bit   mon_on = 1'b0;
   int   vld_cnt_m = 0, seq_err_m = 0, inact_err_m = 0, hold_err_m = 0, nv_busy_m = 0;
   int   vld_cnt_s = 0, seq_err_s = 0, inact_err_s = 0, hold_err_s = 0, nv_busy_s = 0;
   int   c_first_m = -1, c_done_m = -1, c_first_s = -1, c_done_s = -1;
   int   rnd_k = 0;
   logic [15:0] last_m = '0, last_s = '0;

   always @(negedge clk) begin
      if (mon_on) begin
         if (op_vld_m) begin
            if (c_first_m < 0) c_first_m = cyc;
            if ({am_m, bm_m} != vld_cnt_m[15:0]) seq_err_m++;
            if (aa_m != 0 || ba_m != 0) inact_err_m++;
            for (int k = 0; k < 5; k++) begin
               if (vld_cnt_m == tbl[k].idx) begin
                  chk("tbl_m_a", am_m, tbl[k].a);
                  chk("tbl_m_b", bm_m, tbl[k].b);
                  chk("tbl_m_prod", 16'(am_m) * 16'(bm_m), tbl[k].prod);
               end
            end
            if (vld_cnt_m == rnd_k) chk("rnd_m_vec", {am_m, bm_m}, rnd_k[15:0]);
            last_m = {am_m, bm_m};
            vld_cnt_m++;
         end else if (busy_m || done_m) begin
            if (busy_m) nv_busy_m++;
            if ({am_m, bm_m} != last_m || aa_m != 0 || ba_m != 0) hold_err_m++;
            if (done_m && c_done_m < 0) c_done_m = cyc;
         end
         if (op_vld_s) begin
            if (c_first_s < 0) c_first_s = cyc;
            if ({aa_s, ba_s} != vld_cnt_s[15:0]) seq_err_s++;
            if (am_s != 0 || bm_s != 0) inact_err_s++;
            for (int k = 0; k < 5; k++) begin
               if (vld_cnt_s == tbl[k].idx) begin
                  chk("tbl_s_a", aa_s, tbl[k].a);
                  chk("tbl_s_b", ba_s, tbl[k].b);
                  chk("tbl_s_sum", 9'(aa_s) + 9'(ba_s), tbl[k].sum);
               end
            end
            last_s = {aa_s, ba_s};
            vld_cnt_s++;
         end else if (busy_s || done_s) begin
            if (busy_s) nv_busy_s++;
            if ({aa_s, ba_s} != last_s || am_s != 0 || bm_s != 0) hold_err_s++;
            if (done_s && c_done_s < 0) c_done_s = cyc;
         end
      end
   end

   initial begin
      tbl[0] = '{idx: 16'h0000, a: 8'h00, b: 8'h00, prod: 16'd0,     sum: 9'd0};
      tbl[1] = '{idx: 16'h0100, a: 8'h01, b: 8'h00, prod: 16'd0,     sum: 9'd1};
      tbl[2] = '{idx: 16'h0305, a: 8'h03, b: 8'h05, prod: 16'd15,    sum: 9'd8};
      tbl[3] = '{idx: 16'h1234, a: 8'h12, b: 8'h34, prod: 16'd936,   sum: 9'd70};
      tbl[4] = '{idx: 16'hFFFF, a: 8'hFF, b: 8'hFF, prod: 16'd65025, sum: 9'd510};
      rnd_k = $urandom_range(16'h0400, 16'hFF00);

      rst_m = 1'b1; rst_s = 1'b1;
      start_m = 1'b0; start_s = 1'b0;
      mode_m = 1'b0; mode_s = 1'b1;
      hold_m = 1'b0; hold_s = 1'b0;
      repeat (3) @(negedge clk);
      rst_m = 1'b0; rst_s = 1'b0;
      @(negedge clk);
      chk("rst_state_m", state_m, ST_IDLE);
      chk("rst_outs_m", {am_m, bm_m, aa_m, ba_m, op_vld_m, busy_m, done_m}, 0);
      chk("rst_err_m", {err_m, fa_m, fb_m}, 0);
      chk("rst_outs_s", {am_s, bm_s, aa_s, ba_s, op_vld_s, busy_s, done_s}, 0);

      // Both sweeps start together; mode changes afterwards must not matter.
      mon_on = 1'b1;
      start_m = 1'b1; start_s = 1'b1;
      @(negedge clk);
      start_m = 1'b0; start_s = 1'b0;
      mode_m = 1'b1; mode_s = 1'b0;
      chk("first_vld_m", op_vld_m, 1);
      chk("first_vec_m", {am_m, bm_m}, 0);

      repeat (256) @(negedge clk);
      chk("pre_hold_vec", {am_m, bm_m}, 16'h0100);
      hold_m = 1'b1;
      repeat (5) @(negedge clk);
      chk("hold_vec", {am_m, bm_m}, 16'h0100);
      chk("hold_vld", op_vld_m, 0);
      start_m = 1'b1;
      repeat (5) @(negedge clk);
      hold_m = 1'b0;
      @(negedge clk);
      start_m = 1'b0;
      chk("start_ignored_busy", busy_m, 1);

      for (int i = 0; i < 70000 && !(done_m && done_s); i++) @(negedge clk);
      chk("sweep_done_reached", {done_m, done_s}, 2'b11);
      repeat (3) @(negedge clk);
      mon_on = 1'b0;

      chk("vec_count_m", vld_cnt_m, 65536);
      chk("seq_err_m", seq_err_m, 0);
      chk("inact_err_m", inact_err_m, 0);
      chk("hold_err_m", hold_err_m, 0);
      chk("novld_busy_m", nv_busy_m, 11);
      chk("done_delay_m", c_done_m - c_first_m, 65547);
      chk("done_level_m", {done_m, busy_m}, 2'b10);
      chk("err_cnt_m", err_m, CHK ? 1 : 0);
      chk("first_err_a_m", fa_m, CHK ? 3 : 0);
      chk("first_err_b_m", fb_m, CHK ? 5 : 0);
      chk("final_vec_m", {am_m, bm_m}, 16'hFFFF);
      chk("vec_count_s", vld_cnt_s, 65536);
      chk("seq_err_s", seq_err_s, 0);
      chk("inact_err_s", inact_err_s, 0);
      chk("hold_err_s", hold_err_s, 0);
      chk("novld_busy_s", nv_busy_s, 0);
      chk("done_delay_s", c_done_s - c_first_s, 65536);
      chk("err_cnt_s", err_s, 0);

      // Reset in the middle of a sweep, then a clean restart.
      mode_m = 1'b0;
      start_m = 1'b1;
      @(negedge clk);
      start_m = 1'b0;
      chk("restart_from_done", {op_vld_m, am_m, bm_m}, {1'b1, 16'h0000});
      chk("restart_err_clr", err_m, 0);
      repeat (16'h1234) @(negedge clk);
      chk("pre_rst_vec", {am_m, bm_m}, 16'h1234);
      rst_m = 1'b1;
      #1;
      chk("mid_rst_state", state_m, ST_IDLE);
      chk("mid_rst_outs", {am_m, bm_m, aa_m, ba_m, op_vld_m, busy_m, done_m}, 0);
      chk("mid_rst_err", {err_m, fa_m, fb_m}, 0);
      @(negedge clk);
      rst_m = 1'b0;
      repeat (3) @(negedge clk);
      chk("post_rst_idle", {state_m, op_vld_m, busy_m}, {ST_IDLE, 2'b00});
      start_m = 1'b1;
      @(negedge clk);
      start_m = 1'b0;
      chk("restart_vec0", {op_vld_m, am_m, bm_m}, {1'b1, 16'h0000});
      @(negedge clk);
      chk("restart_vec1", {op_vld_m, am_m, bm_m}, {1'b1, 16'h0001});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mul_adr_opgen.md
MUL_ADR_OPGEN -- requirements
Module: mul_adr_opgen

Interface
REQ-001 SHALL have parameter LAT, default 1, giving the consumer's result latency in clock cycles (legal range 0..4).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; every register is clocked on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: request a sweep; sampled only in IDLE or DONE.
REQ-005 SHALL have port mode, input, 1 bit: operation select, 0 = multiply, 1 = add; sampled together with start.
REQ-006 SHALL have port hold, input, 1 bit: pause the sweep.
REQ-007 SHALL have ports am_out and bm_out, output, 8 bits each: multiplier operands.
REQ-008 SHALL have ports aa_out and ba_out, output, 8 bits each: adder operands.
REQ-009 SHALL have port op_vld, output, 1 bit: the operands on the output ports are a new test vector.
REQ-010 SHALL have port p_in, input, 16 bits: product returned by the consumer.
REQ-011 SHALL have port s_in, input, 9 bits: sum returned by the consumer.
REQ-012 SHALL have ports busy and done, output, 1 bit each: sweep in progress, and sweep complete.
REQ-013 SHALL have port err_cnt, output, 17 bits: mismatch count.
REQ-014 SHALL have ports first_err_a and first_err_b, output, 8 bits each: operands of the first mismatch.

Function
REQ-015 SHALL implement an FSM with states IDLE, RUN, DRAIN and DONE.
REQ-016 SHALL, on start in IDLE or DONE, latch mode, clear the 16-bit vector counter tv, clear err_cnt and first_err_*, and enter RUN.
REQ-017 SHALL, in RUN, drive a = tv[15:8] and b = tv[7:0] on the active port pair each cycle, assert op_vld, and increment tv; the first vector appears in the cycle after start is sampled.
REQ-018 SHALL drive the inactive port pair to 0 for the whole sweep: am/bm = 0 when mode = 1, and aa/ba = 0 when mode = 0.
REQ-019 SHALL, while hold = 1 in RUN, deassert op_vld, freeze tv, and keep the operand outputs at their last values.
REQ-020 SHALL, after presenting vector 0xFFFF, enter DRAIN for LAT cycles (0 cycles when LAT = 0), then enter DONE; tv wrap-around is never presented.
REQ-021 SHALL assert busy in RUN and DRAIN, and assert done as a level in DONE until the next start.
REQ-022 SHALL ignore start in RUN and DRAIN.
REQ-023 SHALL carry {vld, a, b, mode} through an LAT-deep delay line; at the delay-line output, when vld = 1, it SHALL compare as follows:
- mode 0: p_in against the full 16-bit product a*b;
- mode 1: s_in against the 9-bit sum a+b.
REQ-024 SHALL compare in the same cycle when LAT = 0.
REQ-025 SHALL, on each mismatch, increment err_cnt, saturating at 0x1FFFF, and capture first_err_a and first_err_b only when err_cnt was 0.
REQ-026 SHALL keep holding operand outputs at 0 in IDLE and at their final values in DONE.

Reset
REQ-027 SHALL, on rst high, immediately return the FSM to IDLE and set every output and tv to 0, including during RUN or DRAIN.
REQ-028 SHALL discard the contents of the delay line on reset.
REQ-029 SHALL, after reset is deasserted, require a fresh start before any new sweep.

Configuration
REQ-030 SHALL use the macro MUL_ADR_OPGEN_CHK_EN to control the compare logic.
REQ-031 SHALL, with MUL_ADR_OPGEN_CHK_EN defined, include the delay line and the compare/count logic per REQ-023..REQ-025.
REQ-032 SHALL, without MUL_ADR_OPGEN_CHK_EN, omit the delay line and compare logic, tie err_cnt and first_err_* to 0, ignore p_in and s_in, and keep the FSM timing (including DRAIN) unchanged; this gives a generator-only netlist for power runs.

Structure
REQ-033 SHALL place OP_W = 8, PROD_W = 16, SUM_W = 9, LAT_MAX = 4 and the FSM state enum in the shared package mul_adr_pkg.
REQ-034 SHALL implement the delay line as the sub-module mul_adr_exp_pipe (parameter LAT), instantiated only under MUL_ADR_OPGEN_CHK_EN.

Verification
REQ-035 SHALL cover: LAT = 1 with an ideal registered multiplier, start with mode = 0 -> first vector (0,0); last vector (255,255) with p = 65025; done 65536+1 cycles after the first vector; err_cnt = 0.
REQ-036 SHALL cover: a model that forces p = 0 for the single vector a = 3, b = 5 -> err_cnt = 1, first_err_a = 3, first_err_b = 5.
REQ-037 SHALL cover: hold high for 10 cycles when tv = 0x0100 -> outputs stay at a = 1, b = 0 with op_vld = 0; done is delayed by exactly 10 cycles.
REQ-038 SHALL cover: mode = 1 with LAT = 0 -> am/bm stay 0 throughout; vector (255,255) is checked against s = 510; err_cnt = 0.
REQ-039 SHALL cover: rst pulse when tv = 0x1234 -> all outputs 0 and FSM in IDLE immediately; a subsequent start restarts the sweep at vector (0,0).
REQ-040 SHALL cover: MUL_ADR_OPGEN_CHK_EN undefined with the fault of REQ-036 injected -> err_cnt = 0; done timing identical to REQ-035.
